// File: rtl/pc_gen_pkg.sv
// ---------------------------------------------------------------------------
// pc_gen_pkg
//
// Purpose:
//    Shared constants and state encodings for the IF-stage fetch-address
//    generator (pc_gen). The control-level constants match the values that
//    the rest of the pipeline uses for reset, chip enable and stall levels.
//
// Contents:
//    RstEnable              level of rst that resets the pipeline
//    ChipEnable/ChipDisable instruction-memory enable levels
//    NoStop/Stop            levels of a stall bit (Stop holds the stage)
//    pcState_e              fetch state encoding
//    nextSeqPc              sequential successor of a fetch address
// ---------------------------------------------------------------------------
package pc_gen_pkg;

    localparam logic RstEnable   = 1'b1;
    localparam logic ChipEnable  = 1'b1;
    localparam logic ChipDisable = 1'b0;
    localparam logic NoStop      = 1'b0;
    localparam logic Stop        = 1'b1;

    // S_OFF : fetch disabled, pc parked at the reset vector
    // S_RUN : normal fetching
    // S_PEND: a branch arrived while IF was stalled and is waiting to apply
    typedef enum logic [1:0] {
        S_OFF  = 2'b00,
        S_RUN  = 2'b01,
        S_PEND = 2'b10
    } pcState_e;

    // Sequential successor of a 32-bit-wide container value. Callers hand in
    // their pc zero-extended and truncate the result back to their width,
    // which gives the required modulo-2^ADDR_W wrap for any ADDR_W <= 32.
    function automatic logic [31:0] nextSeqPc(input logic [31:0] curPc,
                                              input logic [31:0] step);
        return curPc + step;
    endfunction

endpackage

// File: rtl/pc_gen.sv
// ---------------------------------------------------------------------------
// pc_gen
//
// Purpose:
//    Fetch-address generator for the IF stage. Produces the instruction
//    memory address and chip enable, follows branch redirects from ID and
//    exception/flush redirects from CTRL, and buffers a branch that arrives
//    while IF is stalled so that it is applied once the stall releases.
//    Every output comes straight from a flip-flop.
//
// Parameters:
//    ADDR_W    pc / target width in bits (up to 32)
//    RESET_VEC pc value held while fetch is disabled
//    STEP      sequential increment in bytes
//    STALL_W   width of the CTRL stall vector (only bit 0 is used here)
//
// Ports:
//    clk             in   rising-edge clock
//    rst             in   synchronous active-high reset
//    stall           in   CTRL stall vector, stall[0]=1 holds IF
//    branch_flag_i   in   ID requests a redirect this cycle
//    branch_target_i in   redirect target
//    flush_i         in   exception/flush from CTRL (highest priority)
//    new_pc_i        in   exception handler address
//    pc              out  fetch address
//    ce              out  instruction-memory enable
//    pend_o          out  a branch is buffered
//    misalign_o      out  fetch address is not STEP-aligned
//
// Configuration:
//    PC_ALIGN_CHECK_EN  when defined, misalign_o flags every fetch address
//                       that is not a multiple of STEP; when undefined,
//                       misalign_o is tied low and no check logic exists.
// ---------------------------------------------------------------------------
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0,
    parameter int                STEP      = 4,
    parameter int                STALL_W   = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               branch_flag_i,
    input  logic [ADDR_W-1:0]  branch_target_i,
    input  logic               flush_i,
    input  logic [ADDR_W-1:0]  new_pc_i,
    output logic [ADDR_W-1:0]  pc,
    output logic               ce,
    output logic               pend_o,
    output logic               misalign_o
);

    pcState_e          r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_pendTgt;
    logic              r_ce;
    logic              r_pend;

    pcState_e          w_nextState;
    logic [ADDR_W-1:0] w_nextPc;
    logic [ADDR_W-1:0] w_nextPendTgt;
    logic [ADDR_W-1:0] w_seqPc;
    logic [ADDR_W-1:0] w_pendChoice;
    logic              w_nextCe;
    logic              w_held;
    logic              w_unusedStall;
    logic [31:0]       w_seqWide;

    // Only stall[0] concerns IF; the upper bits belong to later stages and
    // are folded into a deliberately unused net.
    assign w_held        = (stall[0] == Stop);
    assign w_unusedStall = ^stall;

    // Sequential successor, computed in a 32-bit container then truncated
    // so that all-ones-minus-(STEP-1) rolls over to zero at any width.
    assign w_seqWide = nextSeqPc(32'(r_pc), 32'(STEP));
    assign w_seqPc   = w_seqWide[ADDR_W-1:0];

    // When leaving S_PEND, a branch presented in the same cycle is newer
    // than the buffered one and takes its place.
    assign w_pendChoice = branch_flag_i ? branch_target_i : r_pendTgt;

    // Next-state / next-pc selection. Flush beats everything, then the stall
    // decides whether a branch applies now or is parked in the buffer.
    always_comb begin
        w_nextState   = r_state;
        w_nextPc      = r_pc;
        w_nextPendTgt = r_pendTgt;

        case (r_state)
            S_OFF: begin
                // First fetch is from the reset vector itself, one cycle
                // after enable comes up.
                w_nextState = S_RUN;
                w_nextPc    = RESET_VEC;
            end

            S_RUN: begin
                if (flush_i) begin
                    w_nextPc = new_pc_i;
                end else if (w_held && branch_flag_i) begin
                    w_nextPendTgt = branch_target_i;
                    w_nextState   = S_PEND;
                end else if (w_held) begin
                    w_nextPc = r_pc;
                end else if (branch_flag_i) begin
                    w_nextPc = branch_target_i;
                end else begin
                    w_nextPc = w_seqPc;
                end
            end

            S_PEND: begin
                if (flush_i) begin
                    w_nextPc    = new_pc_i;
                    w_nextState = S_RUN;
                end else begin
                    w_nextPendTgt = w_pendChoice;
                    if (stall[0] == NoStop) begin
                        w_nextPc    = w_pendChoice;
                        w_nextState = S_RUN;
                    end
                end
            end

            default: begin
                w_nextState = S_OFF;
                w_nextPc    = RESET_VEC;
            end
        endcase

        w_nextCe = (w_nextState != S_OFF) ? ChipEnable : ChipDisable;
    end

    // State, pc, buffered target and the decoded enable/pending flags all
    // update together so every output is a plain register.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            r_state   <= S_OFF;
            r_pc      <= RESET_VEC;
            r_pendTgt <= RESET_VEC;
            r_ce      <= ChipDisable;
            r_pend    <= 1'b0;
        end else begin
            r_state   <= w_nextState;
            r_pc      <= w_nextPc;
            r_pendTgt <= w_nextPendTgt;
            r_ce      <= w_nextCe;
            r_pend    <= (w_nextState == S_PEND);
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    logic r_misalign;
    logic w_nextMisalign;

    // The flag is computed from the value pc is about to take, so it is
    // high in exactly the cycle the bad address is on pc. pc itself still
    // loads the bad value; CTRL decides what to do about it.
    assign w_nextMisalign = w_nextCe &&
                            ((w_nextPc % ADDR_W'(STEP)) != '0);

    // Alignment flag register, cleared with the rest of the fetch state.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= w_nextMisalign;
        end
    end

    assign misalign_o = r_misalign;
`else
    assign misalign_o = 1'b0;
`endif

    assign pc     = r_pc;
    assign ce     = r_ce;
    assign pend_o = r_pend;

endmodule
